// File: rtl/wb_grf.sv
// Write-back stage register file: decodes the W-stage instruction into a commit and holds 32x32 GPRs.
// Optional macro GRF_BYPASS_EN forwards the in-flight write to the D-stage read ports.
module wb_grf (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] W_instr,
    input  logic [31:0] W_PC,
    input  logic [31:0] W_ALU,
    input  logic [31:0] W_DM,
    input  logic        W_flag,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    output logic [31:0] D_rs_data,
    output logic [31:0] D_rt_data,
    output logic        wb_we,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_JALR  = 6'b001001;

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] pc_plus8;
    logic        dec_we;
    logic [4:0]  dec_dest;
    logic [31:0] dec_data;
    logic        unused_instr;

    assign opcode   = W_instr[31:26];
    assign funct    = W_instr[5:0];
    assign rt       = W_instr[20:16];
    assign rd       = W_instr[15:11];
    assign pc_plus8 = W_PC + 32'd8;
    assign unused_instr = ^{W_instr[25:21], W_instr[10:6]};

    always_comb begin
        dec_we   = 1'b0;
        dec_dest = 5'd0;
        dec_data = 32'd0;
        case (opcode)
            OP_RTYPE: begin
                if (funct == FN_ADD || funct == FN_SUB) begin
                    dec_we   = 1'b1;
                    dec_dest = rd;
                    dec_data = W_ALU;
                end else if (funct == FN_JALR) begin
                    dec_we   = 1'b1;
                    dec_dest = rd;
                    dec_data = pc_plus8;
                end
            end
            OP_ORI, OP_LUI: begin
                dec_we   = 1'b1;
                dec_dest = rt;
                dec_data = W_ALU;
            end
            OP_LW: begin
                dec_we   = 1'b1;
                dec_dest = rt;
                dec_data = W_DM;
            end
            OP_JAL: begin
                dec_we   = 1'b1;
                dec_dest = 5'd31;
                dec_data = pc_plus8;
            end
            default: ;
        endcase
    end

    // Outputs stay zeroed when nothing commits, so $0 writes never reach the array.
    always_comb begin
        wb_we   = dec_we && !W_flag && (dec_dest != 5'd0);
        wb_addr = wb_we ? dec_dest : 5'd0;
        wb_data = wb_we ? dec_data : 32'd0;
    end

    always_comb begin
        for (int i = 0; i < 32; i++) regs_d[i] = regs_q[i];
        if (wb_we) regs_d[wb_addr] = wb_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
        end else begin
            for (int i = 0; i < 32; i++) regs_q[i] <= regs_d[i];
        end
    end

    always_comb begin
        D_rs_data = (D_rs == 5'd0) ? 32'd0 : regs_q[D_rs];
        D_rt_data = (D_rt == 5'd0) ? 32'd0 : regs_q[D_rt];
`ifdef GRF_BYPASS_EN
        if (wb_we && D_rs != 5'd0 && wb_addr == D_rs) D_rs_data = wb_data;
        if (wb_we && D_rt != 5'd0 && wb_addr == D_rt) D_rt_data = wb_data;
`endif
    end
endmodule

// File: tb/tb_wb_grf.sv
// Directed scoreboard bench for wb_grf: expectations queued at drive time, popped at sample time.
module tb_wb_grf;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] W_instr, W_PC, W_ALU, W_DM;
    logic        W_flag;
    logic [4:0]  D_rs, D_rt;
    logic [31:0] D_rs_data, D_rt_data;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];
    logic [31:0] model [32];

    wb_grf dut (
        .clk(clk), .reset(reset),
        .W_instr(W_instr), .W_PC(W_PC), .W_ALU(W_ALU), .W_DM(W_DM), .W_flag(W_flag),
        .D_rs(D_rs), .D_rt(D_rt), .D_rs_data(D_rs_data), .D_rt_data(D_rt_data),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [31:0] dm, input logic flag);
        W_instr = instr; W_PC = pc; W_ALU = alu; W_DM = dm; W_flag = flag;
    endtask

    // Check the combinational commit outputs for the currently driven W inputs.
    task automatic chk_wb(input string tag, input logic we, input logic [4:0] addr,
                          input logic [31:0] data);
        push({tag, "_we"}, {31'd0, we});
        push({tag, "_addr"}, {27'd0, addr});
        push({tag, "_data"}, data);
        #1;
        pop_chk({31'd0, wb_we});
        pop_chk({27'd0, wb_addr});
        pop_chk(wb_data);
    endtask

    task automatic chk_read(input string tag, input logic [4:0] rs, input logic [4:0] rt_a,
                            input logic [31:0] exp_rs, input logic [31:0] exp_rt);
        D_rs = rs; D_rt = rt_a;
        push({tag, "_rs"}, exp_rs);
        push({tag, "_rt"}, exp_rt);
        #1;
        pop_chk(D_rs_data);
        pop_chk(D_rt_data);
    endtask

    // Drive a W instruction, check its commit, clock it in and mirror it into the model.
    task automatic wb_step(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                           input logic [31:0] alu, input logic [31:0] dm, input logic flag,
                           input logic we, input logic [4:0] addr, input logic [31:0] data);
        drive(instr, pc, alu, dm, flag);
        chk_wb(tag, we, addr, data);
        step();
        if (we) model[addr] = data;
        drive(32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    endtask

    initial begin
        logic [31:0] exp9;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        reset = 1'b1; D_rs = 5'd0; D_rt = 5'd0;
        drive(32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        step();
        step();
        reset = 1'b0;

        for (int a = 0; a < 32; a++)
            chk_read($sformatf("reset_rd%0d", a), a[4:0], 5'(31 - a), 32'd0, 32'd0);

        wb_step("ori5", 32'h3405ABCD, 32'h0, 32'h0000ABCD, 32'h0, 1'b0, 1'b1, 5'd5, 32'h0000ABCD);
        chk_wb("nop", 1'b0, 5'd0, 32'd0);
        chk_read("rd5", 5'd5, 5'd5, 32'h0000ABCD, 32'h0000ABCD);

        drive(32'h0C000C00, 32'h00003000, 32'h0, 32'h0, 1'b0);
        chk_wb("jal", 1'b1, 5'd31, 32'h00003008);
        wb_step("jal_wrap", 32'h0C000C00, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b0, 1'b1, 5'd31, 32'h00000004);
        chk_read("rd31", 5'd31, 5'd0, 32'h00000004, 32'd0);

        wb_step("lw0", 32'h8C000000, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 32'd0);
        wb_step("add7_cancel", 32'h00223820, 32'h0, 32'h11110000, 32'h0, 1'b1, 1'b0, 5'd0, 32'd0);
        chk_read("rd7_rd0", 5'd7, 5'd0, 32'd0, 32'd0);

        drive(32'h8C090000, 32'h0, 32'h0, 32'h12345678, 1'b0);
`ifdef GRF_BYPASS_EN
        exp9 = 32'h12345678;
`else
        exp9 = 32'd0;
`endif
        chk_wb("lw9", 1'b1, 5'd9, 32'h12345678);
        chk_read("rd9_pre", 5'd9, 5'd9, exp9, exp9);
        step();
        model[9] = 32'h12345678;
        drive(32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        chk_read("rd9_post", 5'd9, 5'd9, 32'h12345678, 32'h12345678);

        wb_step("sub8", 32'h00224022, 32'h0, 32'h00001111, 32'h0, 1'b0, 1'b1, 5'd8, 32'h00001111);
        wb_step("jalr10", 32'h00205009, 32'h00000100, 32'h0, 32'h0, 1'b0, 1'b1, 5'd10, 32'h00000108);
        wb_step("lui4", 32'h3C040000, 32'h0, 32'hABCD0000, 32'h0, 1'b0, 1'b1, 5'd4, 32'hABCD0000);
        wb_step("jr", 32'h03E00008, 32'h00000200, 32'h55555555, 32'h0, 1'b0, 1'b0, 5'd0, 32'd0);
        wb_step("nop_alu", 32'h00000000, 32'h0, 32'h77777777, 32'h0, 1'b0, 1'b0, 5'd0, 32'd0);
        for (int a = 0; a < 32; a++)
            chk_read($sformatf("model_rd%0d", a), a[4:0], 5'(31 - a), model[a], model[31 - a]);

        // Reset wins over a simultaneous commit, while wb_* still decode.
        reset = 1'b1;
        drive(32'h00221820, 32'h0, 32'h00000077, 32'h0, 1'b0);
        chk_wb("add3_rst", 1'b1, 5'd3, 32'h00000077);
        step();
        reset = 1'b0;
        drive(32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        chk_read("rd3_rd5_after_rst", 5'd3, 5'd5, 32'd0, 32'd0);
        chk_read("rd31_rd9_after_rst", 5'd31, 5'd9, 32'd0, 32'd0);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
